// File: rtl/toast_prog_loader_if.sv
// toast_prog_loader_if: byte stream in and word-write port out for toast_prog_loader
interface toast_prog_loader_if;
    logic        Rx_valid;
    logic [7:0]  Rx_data;
    logic        Rx_ready;
    logic        Mem_wr_en;
    logic [31:0] Mem_wr_addr;
    logic [31:0] Mem_wr_data;
    logic [3:0]  Mem_wr_byte_en;
    modport master (
        output Rx_valid, Rx_data,
        input  Rx_ready, Mem_wr_en, Mem_wr_addr, Mem_wr_data, Mem_wr_byte_en
    );
    modport slave (
        input  Rx_valid, Rx_data,
        output Rx_ready, Mem_wr_en, Mem_wr_addr, Mem_wr_data, Mem_wr_byte_en
    );
endinterface

// File: rtl/toast_prog_loader.sv
// toast_prog_loader: streams a length-prefixed LE image into program memory while holding the core.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte over the data bytes.
module toast_prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 65536
) (
    input  logic               Clk,
    input  logic               Reset,
    toast_prog_loader_if.slave bus,
    input  logic               Load_req,
    output logic               Core_hold,
    output logic               Done,
    output logic               Error
);
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_RUN, S_ERROR} state_t;
    logic [7:0] csum;
`else
    typedef enum logic [2:0] {S_LEN, S_DATA, S_RUN, S_ERROR} state_t;
`endif
    state_t      state;
    logic [1:0]  byte_cnt;
    logic [31:0] len;
    logic [31:0] word_idx;
    logic [23:0] asm_word;
    logic        fire;
    logic        last_byte;
    logic [31:0] len_nx;
    logic [31:0] word_nx;
    assign fire      = bus.Rx_valid && bus.Rx_ready;
    assign last_byte = fire && byte_cnt == 2'd3;
    assign len_nx    = {bus.Rx_data, len[31:8]};
    assign word_nx   = {bus.Rx_data, asm_word};
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state              <= S_LEN;
            byte_cnt           <= 2'd0;
            len                <= 32'd0;
            word_idx           <= 32'd0;
            asm_word           <= 24'd0;
            bus.Rx_ready       <= 1'b1;
            bus.Mem_wr_en      <= 1'b0;
            bus.Mem_wr_addr    <= BASE_ADDR;
            bus.Mem_wr_data    <= 32'd0;
            bus.Mem_wr_byte_en <= 4'b0000;
            Core_hold          <= 1'b1;
            Done               <= 1'b0;
            Error              <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum               <= 8'd0;
`endif
        end else begin
            bus.Mem_wr_en      <= 1'b0;
            bus.Mem_wr_byte_en <= 4'b0000;
            case (state)
                S_LEN: if (fire) begin
                    len      <= len_nx;
                    byte_cnt <= byte_cnt + 2'd1;
                    if (last_byte) begin
                        if (len_nx > MEM_WORDS) begin
                            state        <= S_ERROR;
                            bus.Rx_ready <= 1'b0;
                            Error        <= 1'b1;
                        end else if (len_nx == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state        <= S_CSUM;
`else
                            state        <= S_RUN;
                            bus.Rx_ready <= 1'b0;
                            Core_hold    <= 1'b0;
                            Done         <= 1'b1;
`endif
                        end else begin
                            state    <= S_DATA;
                            word_idx <= 32'd0;
                        end
                    end
                end
                S_DATA: if (fire) begin
                    asm_word <= word_nx[31:8];
                    byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum     <= csum ^ bus.Rx_data;
`endif
                    if (last_byte) begin
                        bus.Mem_wr_en      <= 1'b1;
                        bus.Mem_wr_byte_en <= 4'b1111;
                        bus.Mem_wr_data    <= word_nx;
                        bus.Mem_wr_addr    <= BASE_ADDR + (word_idx << 2);
                        word_idx           <= word_idx + 32'd1;
                        if (word_idx == len - 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
                            state        <= S_CSUM;
`else
                            // Release lags one cycle in RUN so the last write lands before the first fetch
                            state        <= S_RUN;
                            bus.Rx_ready <= 1'b0;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: if (fire) begin
                    bus.Rx_ready <= 1'b0;
                    if (bus.Rx_data == csum) begin
                        state     <= S_RUN;
                        Core_hold <= 1'b0;
                        Done      <= 1'b1;
                    end else begin
                        state <= S_ERROR;
                        Error <= 1'b1;
                    end
                end
`endif
                S_RUN: begin
                    Core_hold <= Load_req;
                    Done      <= !Load_req;
                    if (Load_req) begin
                        state        <= S_LEN;
                        bus.Rx_ready <= 1'b1;
                        byte_cnt     <= 2'd0;
                        len          <= 32'd0;
                        word_idx     <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
                        csum         <= 8'd0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_toast_prog_loader.sv
// tb_toast_prog_loader: directed checks of the program loader at BASE_ADDR 0x0 and 0x2000.
module tb_toast_prog_loader;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Load_req = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       hold0, done0, err0, hold1, done1, err1;
    logic [7:0] tb_xor = 8'h00;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [31:0] w0_addr[64];
    logic [31:0] w0_data[64];
    logic [31:0] w1_addr[64];
    int          w0_cyc[64];
    int          w1_cyc[64];
    int          w0_n = 0;
    int          w1_n = 0;
    int          be_bad = 0;
    toast_prog_loader_if bus0();
    toast_prog_loader_if bus1();
    assign bus0.Rx_valid = rx_valid;
    assign bus0.Rx_data  = rx_data;
    assign bus1.Rx_valid = rx_valid;
    assign bus1.Rx_data  = rx_data;
    toast_prog_loader #(.BASE_ADDR(32'h0000_0000), .MEM_WORDS(65536)) dut0 (
        .Clk(Clk), .Reset(Reset), .bus(bus0), .Load_req(Load_req),
        .Core_hold(hold0), .Done(done0), .Error(err0)
    );
    toast_prog_loader #(.BASE_ADDR(32'h0000_2000), .MEM_WORDS(65536)) dut1 (
        .Clk(Clk), .Reset(Reset), .bus(bus1), .Load_req(Load_req),
        .Core_hold(hold1), .Done(done1), .Error(err1)
    );
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;
    always @(negedge Clk) begin
        if (bus0.Mem_wr_en && w0_n < 64) begin
            w0_addr[w0_n] = bus0.Mem_wr_addr;
            w0_data[w0_n] = bus0.Mem_wr_data;
            w0_cyc[w0_n]  = cyc;
            w0_n++;
        end
        if (bus1.Mem_wr_en && w1_n < 64) begin
            w1_addr[w1_n] = bus1.Mem_wr_addr;
            w1_cyc[w1_n]  = cyc;
            w1_n++;
        end
        if (bus0.Mem_wr_byte_en !== (bus0.Mem_wr_en ? 4'b1111 : 4'b0000)) be_bad++;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        rx_valid = 1'b0;
        Load_req = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        tb_xor = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, input bit is_data);
        int t;
        t = 0;
        if (gap) begin
            rx_valid = 1'b0;
            tick();
        end
        rx_valid = 1'b1;
        rx_data = b;
        while (!bus0.Rx_ready && t < 50) begin
            tick();
            t++;
        end
        if (!bus0.Rx_ready) begin
            checks++;
            failures++;
            $display("FAIL send_byte_ready actual=0 required=1");
        end
        tick();
        rx_valid = 1'b0;
        if (is_data) tb_xor ^= b;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap, input bit is_data);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap, is_data);
    endtask

    task automatic send_csum();
`ifdef LOADER_CHECKSUM_EN
        send_byte(tb_xor, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        checks++; if (bus0.Rx_ready !== 1'b1) begin failures++; $display("FAIL reset_rx_ready actual=%b required=1", bus0.Rx_ready); end
        checks++; if (bus0.Mem_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en actual=%b required=0", bus0.Mem_wr_en); end
        checks++; if (bus0.Mem_wr_addr !== 32'h0) begin failures++; $display("FAIL reset_addr0 actual=%h required=00000000", bus0.Mem_wr_addr); end
        checks++; if (bus1.Mem_wr_addr !== 32'h2000) begin failures++; $display("FAIL reset_addr1 actual=%h required=00002000", bus1.Mem_wr_addr); end
        checks++; if (bus0.Mem_wr_data !== 32'h0) begin failures++; $display("FAIL reset_data actual=%h required=00000000", bus0.Mem_wr_data); end
        checks++; if (bus0.Mem_wr_byte_en !== 4'h0) begin failures++; $display("FAIL reset_byte_en actual=%h required=0", bus0.Mem_wr_byte_en); end
        checks++; if ({hold0, done0, err0} !== 3'b100) begin failures++; $display("FAIL reset_hold_done_err actual=%b required=100", {hold0, done0, err0}); end
        Reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        send_word(32'h0000_0001, 1'b0, 1'b0);
        send_word(32'h0000_0513, 1'b0, 1'b1);
        checks++; if (bus0.Mem_wr_en !== 1'b1) begin failures++; $display("FAIL single_wr_en actual=%b required=1", bus0.Mem_wr_en); end
        checks++; if (bus0.Mem_wr_addr !== 32'h0) begin failures++; $display("FAIL single_addr actual=%h required=00000000", bus0.Mem_wr_addr); end
        checks++; if (bus0.Mem_wr_data !== 32'h0000_0513) begin failures++; $display("FAIL single_data actual=%h required=00000513", bus0.Mem_wr_data); end
        checks++; if (bus0.Mem_wr_byte_en !== 4'hF) begin failures++; $display("FAIL single_byte_en actual=%h required=f", bus0.Mem_wr_byte_en); end
        checks++; if (hold0 !== 1'b1) begin failures++; $display("FAIL single_hold_at_strobe actual=%b required=1", hold0); end
`ifdef LOADER_CHECKSUM_EN
        send_csum();
`else
        tick();
`endif
        checks++; if ({hold0, done0, bus0.Rx_ready, bus0.Mem_wr_en} !== 4'b0100) begin failures++; $display("FAIL single_release actual=%b required=0100", {hold0, done0, bus0.Rx_ready, bus0.Mem_wr_en}); end
    endtask

    task automatic test_stall();
        int s;
        do_reset();
        s = w0_n;
        send_word(32'd3, 1'b1, 1'b0);
        send_word(32'h1122_3344, 1'b1, 1'b1);
        Load_req = 1'b1;
        tick();
        Load_req = 1'b0;
        send_word(32'hA5A5_5A5A, 1'b1, 1'b1);
        send_word(32'hDEAD_BEEF, 1'b1, 1'b1);
        send_csum();
        repeat (3) tick();
        checks++; if (w0_n - s !== 3) begin failures++; $display("FAIL stall_count actual=%0d required=3", w0_n - s); end
        checks++; if ({w0_addr[s], w0_addr[s+1], w0_addr[s+2]} !== {32'h0, 32'h4, 32'h8}) begin failures++; $display("FAIL stall_addrs actual=%h,%h,%h required=0,4,8", w0_addr[s], w0_addr[s+1], w0_addr[s+2]); end
        checks++; if ({w0_data[s], w0_data[s+1], w0_data[s+2]} !== {32'h1122_3344, 32'hA5A5_5A5A, 32'hDEAD_BEEF}) begin failures++; $display("FAIL stall_data actual=%h,%h,%h required=11223344,a5a55a5a,deadbeef", w0_data[s], w0_data[s+1], w0_data[s+2]); end
        checks++; if ({hold0, done0} !== 2'b01) begin failures++; $display("FAIL stall_release actual=%b required=01", {hold0, done0}); end
    endtask

    task automatic test_back_to_back();
        int s0, s1;
        do_reset();
        s0 = w0_n;
        s1 = w1_n;
        send_word(32'd2, 1'b0, 1'b0);
        send_word(32'h0000_0001, 1'b0, 1'b1);
        send_word(32'h0000_0002, 1'b0, 1'b1);
        send_csum();
        repeat (2) tick();
        checks++; if (w1_n - s1 !== 2) begin failures++; $display("FAIL b2b_count actual=%0d required=2", w1_n - s1); end
        checks++; if ({w1_addr[s1], w1_addr[s1+1]} !== {32'h2000, 32'h2004}) begin failures++; $display("FAIL b2b_addrs actual=%h,%h required=2000,2004", w1_addr[s1], w1_addr[s1+1]); end
        checks++; if (w1_cyc[s1+1] - w1_cyc[s1] !== 4) begin failures++; $display("FAIL b2b_spacing actual=%0d required=4", w1_cyc[s1+1] - w1_cyc[s1]); end
        checks++; if ({w0_data[s0], w0_data[s0+1]} !== {32'h1, 32'h2}) begin failures++; $display("FAIL b2b_data actual=%h,%h required=1,2", w0_data[s0], w0_data[s0+1]); end
    endtask

    task automatic test_len_error();
        int s;
        do_reset();
        s = w0_n;
        send_word(32'h0001_0001, 1'b0, 1'b0);
        checks++; if ({err0, hold0, bus0.Rx_ready} !== 3'b110) begin failures++; $display("FAIL len_err_enter actual=%b required=110", {err0, hold0, bus0.Rx_ready}); end
        rx_valid = 1'b1;
        rx_data = 8'h5A;
        Load_req = 1'b1;
        tick();
        Load_req = 1'b0;
        repeat (8) tick();
        rx_valid = 1'b0;
        checks++; if ({err0, hold0, done0, bus0.Rx_ready} !== 4'b1100) begin failures++; $display("FAIL len_err_sticky actual=%b required=1100", {err0, hold0, done0, bus0.Rx_ready}); end
        checks++; if (w0_n !== s) begin failures++; $display("FAIL len_err_strobes actual=%0d required=%0d", w0_n, s); end
        do_reset();
        checks++; if ({err0, bus0.Rx_ready} !== 2'b01) begin failures++; $display("FAIL len_err_cleared actual=%b required=01", {err0, bus0.Rx_ready}); end
    endtask

    task automatic test_zero_len();
        int s;
        do_reset();
        s = w0_n;
        send_word(32'd0, 1'b0, 1'b0);
        send_csum();
        checks++; if ({hold0, done0, bus0.Rx_ready, err0} !== 4'b0100) begin failures++; $display("FAIL zero_len_release actual=%b required=0100", {hold0, done0, bus0.Rx_ready, err0}); end
        checks++; if (w0_n !== s) begin failures++; $display("FAIL zero_len_strobes actual=%0d required=%0d", w0_n, s); end
    endtask

    task automatic test_reload();
        int s;
        do_reset();
        s = w0_n;
        send_word(32'd1, 1'b0, 1'b0);
        send_word(32'h1234_5678, 1'b0, 1'b1);
        send_csum();
        repeat (2) tick();
        checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL reload_first_done actual=%b required=1", done0); end
        Load_req = 1'b1;
        tick();
        Load_req = 1'b0;
        tb_xor = 8'h00;
        checks++; if ({hold0, done0, bus0.Rx_ready} !== 3'b101) begin failures++; $display("FAIL reload_rehold actual=%b required=101", {hold0, done0, bus0.Rx_ready}); end
        send_word(32'd1, 1'b0, 1'b0);
        send_word(32'hCAFE_F00D, 1'b0, 1'b1);
        send_csum();
        tick();
        checks++; if (w0_n - s !== 2 || w0_addr[s+1] !== 32'h0 || w0_data[s+1] !== 32'hCAFE_F00D) begin failures++; $display("FAIL reload_write actual=n%0d,%h,%h required=n2,00000000,cafef00d", w0_n - s, w0_addr[s+1], w0_data[s+1]); end
        checks++; if ({hold0, done0} !== 2'b01) begin failures++; $display("FAIL reload_release actual=%b required=01", {hold0, done0}); end
    endtask

    task automatic test_reset_mid();
        int s;
        do_reset();
        s = w0_n;
        send_word(32'd1, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b1);
        send_byte(8'h22, 1'b0, 1'b1);
        send_byte(8'h33, 1'b0, 1'b1);
        rx_valid = 1'b1;
        rx_data = 8'h44;
        Reset = 1'b1;
        tick();
        rx_valid = 1'b0;
        checks++; if (bus0.Mem_wr_en !== 1'b0) begin failures++; $display("FAIL reset_mid_cycle0 actual=%b required=0", bus0.Mem_wr_en); end
        tick();
        Reset = 1'b0;
        tick();
        checks++; if (bus0.Mem_wr_en !== 1'b0 || w0_n !== s) begin failures++; $display("FAIL reset_mid_strobes actual=%b/%0d required=0/%0d", bus0.Mem_wr_en, w0_n, s); end
        checks++; if ({hold0, bus0.Rx_ready} !== 2'b11) begin failures++; $display("FAIL reset_mid_state actual=%b required=11", {hold0, bus0.Rx_ready}); end
    endtask

    task automatic test_checksum();
`ifdef LOADER_CHECKSUM_EN
        int s;
        do_reset();
        send_word(32'd1, 1'b0, 1'b0);
        send_word(32'hDDCC_BBAA, 1'b0, 1'b1);
        send_byte(8'h00, 1'b0, 1'b0);
        checks++; if ({done0, err0, hold0} !== 3'b100) begin failures++; $display("FAIL csum_good actual=%b required=100", {done0, err0, hold0}); end
        do_reset();
        s = w0_n;
        send_word(32'd1, 1'b0, 1'b0);
        send_word(32'hDDCC_BBAA, 1'b0, 1'b1);
        send_byte(8'h01, 1'b0, 1'b0);
        checks++; if ({done0, err0, hold0} !== 3'b011) begin failures++; $display("FAIL csum_bad actual=%b required=011", {done0, err0, hold0}); end
        checks++; if (w0_n - s !== 1 || w0_data[s] !== 32'hDDCC_BBAA) begin failures++; $display("FAIL csum_bad_write actual=n%0d,%h required=n1,ddccbbaa", w0_n - s, w0_data[s]); end
`endif
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_len_error();
        test_zero_len();
        test_reload();
        test_reset_mid();
        test_checksum();
        checks++; if (be_bad !== 0) begin failures++; $display("FAIL byte_en_consistency actual=%0d required=0", be_bad); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
